tcdm_slave_mem: RTL and testbench



---
 rtl/tcdm_slave_pkg.sv | 14 +
 rtl/tcdm_slave_decode.sv | 22 ++
 rtl/tcdm_slave_mem.sv | 152 +++++++++++++++
 tb/tb_tcdm_slave_mem.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tcdm_slave_pkg.sv
// Shared types and constants for the TCDM slave memory model.
package tcdm_slave_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } tcdm_slave_state_e;

  localparam logic        TCDM_OPC_OK    = 1'b0;
  localparam logic        TCDM_OPC_ERR   = 1'b1;
  localparam logic [31:0] TCDM_ERR_RDATA = 32'h0;

endpackage

// File: rtl/tcdm_slave_decode.sv
// Address decoder: flags whether a byte address falls inside the array window
// and extracts the word index.
module tcdm_slave_decode #(
  parameter int unsigned NUM_WORDS = 256,
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter int unsigned IDX_W     = $clog2(NUM_WORDS)
) (
  input  logic [31:0]      add,
  output logic             hit,
  output logic [IDX_W-1:0] idx
);

  logic [32:0] upper;

  // Compare in 33 bits so a window touching the top of the address space cannot wrap.
  always_comb begin
    upper = {1'b0, BASE_ADDR} + 33'(4 * NUM_WORDS);
    hit   = ({1'b0, add} >= {1'b0, BASE_ADDR}) && ({1'b0, add} < upper);
    idx   = add[IDX_W+1:2];
  end

endmodule

// File: rtl/tcdm_slave_mem.sv
// TCDM responder: word-addressed memory with configurable wait states,
// one response per granted request, error response for out-of-range addresses.
module tcdm_slave_mem
  import tcdm_slave_pkg::*;
#(
  parameter int unsigned NUM_WORDS   = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        tcdm_req_i,
  input  logic [31:0] tcdm_add_i,
  input  logic        tcdm_wen_i,
  input  logic [31:0] tcdm_wdata_i,
  input  logic [3:0]  tcdm_be_i,
  output logic        tcdm_gnt_o,
  output logic        tcdm_r_valid_o,
  output logic [31:0] tcdm_r_rdata_o,
  output logic        tcdm_r_opc_o
);

  localparam int unsigned IDX_W = $clog2(NUM_WORDS);

  tcdm_slave_state_e state, state_nxt;
  logic [2:0]        cnt, cnt_nxt;

  logic              dec_hit;
  logic [IDX_W-1:0]  dec_idx;

  logic              hit_q, wen_q;
  logic [IDX_W-1:0]  idx_q;
  logic [31:0]       wdata_q;
  logic [3:0]        be_q;

  logic              hs, commit;
  logic              c_hit, c_wen;
  logic [IDX_W-1:0]  c_idx;
  logic [31:0]       c_wdata;
  logic [3:0]        c_be;

  logic [31:0]       mem [NUM_WORDS];

  tcdm_slave_decode #(
    .NUM_WORDS (NUM_WORDS),
    .BASE_ADDR (BASE_ADDR),
    .IDX_W     (IDX_W)
  ) u_decode (
    .add (tcdm_add_i),
    .hit (dec_hit),
    .idx (dec_idx)
  );

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    tcdm_gnt_o     = 1'b0;
    tcdm_r_valid_o = (state == RESP);
    if ((state == IDLE || state == RESP) && !rst_i) begin
      tcdm_gnt_o = tcdm_req_i;
    end
    hs = tcdm_req_i & tcdm_gnt_o;
    case (state)
      IDLE, RESP: begin
        if (hs) begin
          if (WAIT_CYCLES > 0) begin
            state_nxt = WAIT;
            cnt_nxt   = 3'(WAIT_CYCLES - 1);
          end else begin
            state_nxt = RESP;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      WAIT: begin
        if (cnt == 3'd0) begin
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt - 3'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // With no wait states the commit edge is the handshake edge itself, so the
  // live request fields are used instead of the latched copy.
  always_comb begin
    commit  = (state == WAIT && cnt == 3'd0) || (hs && WAIT_CYCLES == 0);
    c_hit   = (WAIT_CYCLES == 0) ? dec_hit      : hit_q;
    c_wen   = (WAIT_CYCLES == 0) ? tcdm_wen_i   : wen_q;
    c_idx   = (WAIT_CYCLES == 0) ? dec_idx      : idx_q;
    c_wdata = (WAIT_CYCLES == 0) ? tcdm_wdata_i : wdata_q;
    c_be    = (WAIT_CYCLES == 0) ? tcdm_be_i    : be_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      cnt     <= '0;
      hit_q   <= 1'b0;
      wen_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (hs) begin
        hit_q   <= dec_hit;
        wen_q   <= tcdm_wen_i;
        idx_q   <= dec_idx;
        wdata_q <= tcdm_wdata_i;
        be_q    <= tcdm_be_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NUM_WORDS; i++) begin
        mem[i] <= '0;
      end
    end else if (commit && c_hit && !c_wen) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (c_be[b]) begin
          mem[c_idx][8*b +: 8] <= c_wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tcdm_r_rdata_o <= '0;
      tcdm_r_opc_o   <= 1'b0;
    end else if (commit) begin
      if (!c_hit) begin
        tcdm_r_rdata_o <= TCDM_ERR_RDATA;
        tcdm_r_opc_o   <= TCDM_OPC_ERR;
      end else if (c_wen) begin
        tcdm_r_rdata_o <= mem[c_idx];
        tcdm_r_opc_o   <= TCDM_OPC_OK;
      end else begin
        tcdm_r_rdata_o <= '0;
        tcdm_r_opc_o   <= TCDM_OPC_OK;
      end
    end
  end

endmodule

// File: tb/tb_tcdm_slave_mem.sv
// Scoreboard bench for tcdm_slave_mem: one instance without and one with wait states.
module tb_tcdm_slave_mem;

  localparam int unsigned NW   = 256;
  localparam logic [31:0] BASE = 32'h1000_0000;

  typedef struct {
    logic [31:0] rdata;
    logic        opc;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        rst   [2];
  logic        req   [2];
  logic [31:0] add   [2];
  logic        wen   [2];
  logic [31:0] wdata [2];
  logic [3:0]  be    [2];
  logic        gnt   [2];
  logic        rv    [2];
  logic [31:0] rdata [2];
  logic        opc   [2];

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  exp_t q0[$];
  exp_t q1[$];
  logic [31:0] mem_m [2][NW];

  tcdm_slave_mem #(.NUM_WORDS(NW), .BASE_ADDR(BASE), .WAIT_CYCLES(0)) dut0 (
    .clk_i(clk), .rst_i(rst[0]), .tcdm_req_i(req[0]), .tcdm_add_i(add[0]),
    .tcdm_wen_i(wen[0]), .tcdm_wdata_i(wdata[0]), .tcdm_be_i(be[0]),
    .tcdm_gnt_o(gnt[0]), .tcdm_r_valid_o(rv[0]), .tcdm_r_rdata_o(rdata[0]),
    .tcdm_r_opc_o(opc[0]));

  tcdm_slave_mem #(.NUM_WORDS(NW), .BASE_ADDR(BASE), .WAIT_CYCLES(3)) dut1 (
    .clk_i(clk), .rst_i(rst[1]), .tcdm_req_i(req[1]), .tcdm_add_i(add[1]),
    .tcdm_wen_i(wen[1]), .tcdm_wdata_i(wdata[1]), .tcdm_be_i(be[1]),
    .tcdm_gnt_o(gnt[1]), .tcdm_r_valid_o(rv[1]), .tcdm_r_rdata_o(rdata[1]),
    .tcdm_r_opc_o(opc[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wc(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic clear_model(input int d);
    for (int i = 0; i < NW; i++) mem_m[d][i] = '0;
  endtask

  // Monitor: every response must match the oldest outstanding expectation.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rv[d] === 1'b1) begin
        exp_t e;
        bit   ok;
        ok = 1'b0;
        if (d == 0 && q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
        if (d == 1 && q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
        if (!ok) begin
          chk($sformatf("unexpected_rvalid_dut%0d", d), 1, 0);
        end else begin
          chk($sformatf("rdata_dut%0d", d), rdata[d], e.rdata);
          chk($sformatf("opc_dut%0d", d), opc[d], e.opc);
          chk($sformatf("latency_dut%0d", d), cyc, e.cyc);
        end
      end
    end
  end

  // Drives a request at a negedge, waits (bounded) for grant, and records the
  // expected response from the reference model. Returns the grant cycle.
  task automatic issue(input int d, input logic [31:0] a, input logic w,
                       input logic [31:0] wd, input logic [3:0] b,
                       input bit track, output int hs);
    int n;
    exp_t e;
    longint unsigned la;
    int idx;
    bit in;
    req[d] = 1'b1; add[d] = a; wen[d] = w; wdata[d] = wd; be[d] = b;
    n = 0;
    #1;
    while (gnt[d] !== 1'b1 && n < 50) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 50) begin
      chk($sformatf("gnt_timeout_dut%0d", d), 0, 1);
      hs = -1;
      req[d] = 1'b0;
      @(negedge clk);
      return;
    end
    hs = cyc;
    la = longint'(a);
    in = (la >= longint'(BASE)) && (la < longint'(BASE) + 4 * NW);
    idx = int'((la - longint'(BASE)) / 4);
    e.cyc = hs + 1 + wc(d);
    if (!in) begin
      e.rdata = 32'h0; e.opc = 1'b1;
    end else if (w) begin
      e.rdata = mem_m[d][idx]; e.opc = 1'b0;
    end else begin
      e.rdata = 32'h0; e.opc = 1'b0;
    end
    if (track) begin
      if (in && !w)
        for (int k = 0; k < 4; k++) if (b[k]) mem_m[d][idx][8*k +: 8] = wd[8*k +: 8];
      if (d == 0) q0.push_back(e); else q1.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int d, input int n);
    req[d] = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0) && n < 100) begin
      @(negedge clk); n++;
    end
    chk("drain_q0", q0.size(), 0);
    chk("drain_q1", q1.size(), 0);
  endtask

  initial begin
    int h1, h2, hp;
    logic [31:0] a;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; req[d] = 1'b0; add[d] = '0; wen[d] = 1'b1; wdata[d] = '0; be[d] = '0;
      clear_model(d);
    end
    repeat (3) @(negedge clk);
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_gnt", gnt[d], 0);
      chk("reset_rvalid", rv[d], 0);
      chk("reset_rdata", rdata[d], 0);
      chk("reset_opc", opc[d], 0);
    end

    // Back-to-back write then read, no wait states
    issue(0, BASE + 8, 1'b0, 32'hDEADBEEF, 4'hF, 1, h1);
    issue(0, BASE + 8, 1'b1, 32'h0, 4'h0, 1, h2);
    chk("b2b_gnt_spacing", h2 - h1, 1);
    idle(0, 3);

    // Byte enables
    issue(0, BASE + 12, 1'b0, 32'h11223344, 4'hF, 1, h1);
    issue(0, BASE + 12, 1'b0, 32'hAABBCCDD, 4'b0101, 1, h1);
    issue(0, BASE + 12, 1'b1, 32'h0, 4'h0, 1, h1);
    idle(0, 3);

    // Wait states: second grant exactly 4 cycles after the first
    issue(1, BASE + 8, 1'b0, 32'hCAFE0001, 4'hF, 1, h1);
    issue(1, BASE + 8, 1'b1, 32'h0, 4'h0, 1, h2);
    chk("wait_gnt_spacing", h2 - h1, 4);
    idle(1, 6);

    // Out of range on both instances, last word guarded
    for (int d = 0; d < 2; d++) begin
      issue(d, BASE + 4 * (NW - 1), 1'b0, 32'h5A5A0FF0, 4'hF, 1, h1);
      issue(d, BASE, 1'b0, 32'h01020304, 4'hF, 1, h1);
      issue(d, BASE + 4 * NW, 1'b0, 32'hFFFFFFFF, 4'hF, 1, h1);
      issue(d, BASE + 4 * NW, 1'b1, 32'h0, 4'h0, 1, h1);
      issue(d, BASE - 4, 1'b1, 32'h0, 4'h0, 1, h1);
      issue(d, BASE + 4 * (NW - 1), 1'b1, 32'h0, 4'h0, 1, h1);
      issue(d, BASE, 1'b1, 32'h0, 4'h0, 1, h1);
      idle(d, 6);
    end
    drain();

    // Reset during WAIT of a write on the wait-state instance
    issue(1, BASE + 16, 1'b0, 32'h77665544, 4'hF, 1, h1);
    issue(1, BASE + 16, 1'b1, 32'h0, 4'h0, 1, h1);
    idle(1, 6);
    drain();
    issue(1, BASE, 1'b0, 32'h12345678, 4'hF, 0, h1);
    rst[1] = 1'b1;
    req[1] = 1'b0;
    #1;
    chk("rst_wait_gnt", gnt[1], 0);
    chk("rst_wait_rvalid", rv[1], 0);
    chk("rst_wait_rdata", rdata[1], 0);
    chk("rst_wait_opc", opc[1], 0);
    @(negedge clk);
    rst[1] = 1'b0;
    clear_model(1);
    idle(1, 6);
    issue(1, BASE, 1'b1, 32'h0, 4'h0, 1, h1);
    issue(1, BASE + 16, 1'b1, 32'h0, 4'h0, 1, h1);
    idle(1, 6);

    // Streaming: fill 16 words, then 16 back-to-back reads
    for (int i = 0; i < 16; i++)
      issue(0, BASE + 32'(4 * (32 + i)), 1'b0, $urandom, 4'hF, 1, h1);
    hp = -1;
    for (int i = 0; i < 16; i++) begin
      issue(0, BASE + 32'(4 * (32 + i)), 1'b1, 32'h0, 4'h0, 1, h1);
      if (hp >= 0) chk("stream_gnt_spacing", h1 - hp, 1);
      hp = h1;
    end
    idle(0, 3);
    drain();

    // Randomized traffic on both instances
    for (int d = 0; d < 2; d++) begin
      for (int t = 0; t < 200; t++) begin
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0)      a = BASE - 32'(4 * $urandom_range(1, 4));
        else if (r == 1) a = BASE + 32'(4 * NW) + 32'(4 * $urandom_range(0, 3));
        else             a = BASE + 32'(4 * $urandom_range(0, 15));
        a = a | 32'($urandom_range(0, 3));
        issue(d, a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)), 1, h1);
        if ($urandom_range(0, 3) == 0) idle(d, int'($urandom_range(1, 3)));
      end
      idle(d, 8);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1);
  end

endmodule
